demux_1to8_ctrl: RTL and testbench

Registered routing controller that sits in front of the 1-to-8 demultiplexer datapath. It accepts one word per handshake from a single upstream source, latches it with its 3-bit destination, and presents it on a shared data bus with a one-hot valid to exactly one of eight downstream consumers. It holds the word until that consumer accepts it. It also filters disabled channels, optionally discards stalled words on timeout, and keeps transfer and drop counters.

---
 rtl/demux_1to8_ctrl.sv | 116 +++++++++++
 tb/tb_demux_1to8_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/demux_1to8_ctrl.sv
// Registered 1-to-8 routing controller: holds one word for a single consumer, filters disabled channels,
// and counts transfers/drops. Optional stall timeout discard is enabled with DEMUX_CTRL_TIMEOUT_EN.
module demux_1to8_ctrl #(
  parameter int W       = 8,
  parameter int TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  input  logic [2:0]   in_dest,
  output logic         in_ready,
  input  logic [7:0]   chan_en,
  output logic [7:0]   y_valid,
  output logic [W-1:0] y_data,
  input  logic [7:0]   y_ready,
  output logic         drop,
  output logic [15:0]  sent_count,
  output logic [7:0]   drop_count
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t      state_r;
  logic [2:0]  dest_r;
  logic        fire_s;
  logic        accept_s;
  logic        acc_en_s;
  logic        acc_dis_s;
  logic        timeout_s;

`ifdef DEMUX_CTRL_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);
  logic [7:0]  timer_r;
`endif

  // Handshake decode; in_ready is combinational from y_ready so a firing slot can be refilled at once.
  always_comb begin
    fire_s    = 1'b0;
    timeout_s = 1'b0;
    if (state_r == HOLD) begin
      fire_s = y_ready[dest_r];
`ifdef DEMUX_CTRL_TIMEOUT_EN
      timeout_s = ~y_ready[dest_r] & (timer_r == TIMEOUT_LAST);
`endif
    end else begin
      fire_s    = 1'b0;
      timeout_s = 1'b0;
    end
    in_ready  = (state_r == IDLE) | fire_s;
    accept_s  = in_valid & in_ready;
    acc_en_s  = accept_s & chan_en[in_dest];
    acc_dis_s = accept_s & ~chan_en[in_dest];
  end

  // Holding register, one-hot valid, drop pulse and event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      dest_r     <= 3'd0;
      y_valid    <= 8'h00;
      y_data     <= '0;
      drop       <= 1'b0;
      sent_count <= 16'd0;
      drop_count <= 8'd0;
`ifdef DEMUX_CTRL_TIMEOUT_EN
      timer_r    <= 8'd0;
`endif
    end else begin
      drop <= acc_dis_s | timeout_s;

      if ((acc_dis_s | timeout_s) && (drop_count != 8'hFF)) begin
        drop_count <= drop_count + 8'd1;
      end else begin
        drop_count <= drop_count;
      end

      if (fire_s) begin
        sent_count <= sent_count + 16'd1;
      end else begin
        sent_count <= sent_count;
      end

      // A disabled-channel accept never disturbs a held word: it is only possible when that word fires.
      if (acc_en_s) begin
        state_r <= HOLD;
        dest_r  <= in_dest;
        y_data  <= in_data;
        y_valid <= 8'h01 << in_dest;
`ifdef DEMUX_CTRL_TIMEOUT_EN
        timer_r <= 8'd0;
`endif
      end else if (fire_s || timeout_s) begin
        state_r <= IDLE;
        y_valid <= 8'h00;
`ifdef DEMUX_CTRL_TIMEOUT_EN
        timer_r <= 8'd0;
`endif
      end else begin
        state_r <= state_r;
        y_valid <= y_valid;
`ifdef DEMUX_CTRL_TIMEOUT_EN
        if (state_r == HOLD) begin
          timer_r <= timer_r + 8'd1;
        end else begin
          timer_r <= timer_r;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_demux_1to8_ctrl.sv
// Directed self-checking bench for demux_1to8_ctrl (default W=8, TIMEOUT=15).
module tb_demux_1to8_ctrl;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic [2:0]  in_dest;
  logic        in_ready;
  logic [7:0]  chan_en;
  logic [7:0]  y_valid;
  logic [7:0]  y_data;
  logic [7:0]  y_ready;
  logic        drop;
  logic [15:0] sent_count;
  logic [7:0]  drop_count;

  int checks_r = 0;
  int errors_r = 0;

  demux_1to8_ctrl #(.W(8), .TIMEOUT(15)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_dest    (in_dest),
    .in_ready   (in_ready),
    .chan_en    (chan_en),
    .y_valid    (y_valid),
    .y_data     (y_data),
    .y_ready    (y_ready),
    .drop       (drop),
    .sent_count (sent_count),
    .drop_count (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_r++;
    if (got !== exp) begin
      errors_r++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    in_dest  = 3'd0;
    chan_en  = 8'hFF;
    y_ready  = 8'h00;
    step();
    rst = 1'b0;
  endtask

  initial begin
    int vcnt;
    int dcnt;

    do_reset();
    check("rst_y_valid", y_valid, 8'h00);
    check("rst_y_data", y_data, 8'h00);
    check("rst_drop", drop, 1'b0);
    check("rst_sent", sent_count, 16'd0);
    check("rst_dropcnt", drop_count, 8'd0);
    check("rst_in_ready", in_ready, 1'b1);

    // Single word to channel 5
    in_valid = 1'b1; in_dest = 3'd5; in_data = 8'hA5; y_ready = 8'h20;
    step();
    in_valid = 1'b0;
    check("t1_y_valid", y_valid, 8'h20);
    check("t1_y_data", y_data, 8'hA5);
    check("t1_sent_pre", sent_count, 16'd0);
    step();
    check("t1_sent", sent_count, 16'd1);
    check("t1_idle_valid", y_valid, 8'h00);
    check("t1_data_hold", y_data, 8'hA5);

    // Back-to-back stream over all channels
    do_reset();
    y_ready = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_dest = 3'(i); in_data = 8'(8'h10 + i);
      #1;
      check("b2b_in_ready", in_ready, 1'b1);
      step();
      check("b2b_y_valid", y_valid, 8'h01 << i);
      check("b2b_y_data", y_data, 8'(8'h10 + i));
    end
    in_valid = 1'b0;
    step();
    check("b2b_sent", sent_count, 16'd8);
    check("b2b_idle", y_valid, 8'h00);

    // Backpressure on channel 3 with next word waiting for channel 6
    do_reset();
    in_valid = 1'b1; in_dest = 3'd3; in_data = 8'h33;
    step();
    in_dest = 3'd6; in_data = 8'h66;
    for (int i = 0; i < 4; i++) begin
      check("bp_y_valid", y_valid, 8'h08);
      check("bp_y_data", y_data, 8'h33);
      check("bp_in_ready", in_ready, 1'b0);
      step();
    end
    y_ready = 8'h08;
    #1;
    check("bp_fire_ready", in_ready, 1'b1);
    step();
    in_valid = 1'b0; y_ready = 8'h00;
    check("bp_next_valid", y_valid, 8'h40);
    check("bp_next_data", y_data, 8'h66);
    check("bp_sent", sent_count, 16'd1);

    // Disabled channel 2
    do_reset();
    chan_en = 8'hFB;
    in_valid = 1'b1; in_dest = 3'd2; in_data = 8'h22;
    #1;
    check("dis_in_ready_pre", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    check("dis_y_valid", y_valid, 8'h00);
    check("dis_drop", drop, 1'b1);
    check("dis_dropcnt", drop_count, 8'd1);
    check("dis_in_ready", in_ready, 1'b1);
    step();
    check("dis_drop_end", drop, 1'b0);
    check("dis_dropcnt_hold", drop_count, 8'd1);

    // drop_count saturates at 255
    do_reset();
    chan_en = 8'h00;
    in_valid = 1'b1;
    for (int i = 0; i < 260; i++) begin
      in_dest = 3'(i);
      step();
    end
    in_valid = 1'b0;
    check("sat_dropcnt", drop_count, 8'd255);
    check("sat_y_valid", y_valid, 8'h00);

    // Stall on channel 1
    do_reset();
    in_valid = 1'b1; in_dest = 3'd1; in_data = 8'h11;
    step();
    in_valid = 1'b0;
`ifdef DEMUX_CTRL_TIMEOUT_EN
    vcnt = 0;
    dcnt = 0;
    for (int i = 0; i < 25; i++) begin
      if (y_valid == 8'h02) vcnt++;
      if (drop) dcnt++;
      step();
    end
    check("to_valid_cycles", vcnt, 15);
    check("to_drop_pulses", dcnt, 1);
    check("to_dropcnt", drop_count, 8'd1);
    check("to_y_valid", y_valid, 8'h00);
    check("to_in_ready", in_ready, 1'b1);
`else
    vcnt = 0;
    dcnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (y_valid == 8'h02) vcnt++;
      if (drop) dcnt++;
      step();
    end
    check("nto_valid_cycles", vcnt, 100);
    check("nto_drop_pulses", dcnt, 0);
    check("nto_y_valid", y_valid, 8'h02);
    check("nto_dropcnt", drop_count, 8'd0);
`endif

    // Reset while holding a word for channel 4
    do_reset();
    y_ready = 8'h01;
    in_valid = 1'b1; in_dest = 3'd0; in_data = 8'h01;
    step();
    in_dest = 3'd4; in_data = 8'h44;
    step();
    in_valid = 1'b0; y_ready = 8'h00;
    check("mr_y_valid_pre", y_valid, 8'h10);
    check("mr_sent_pre", sent_count, 16'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mr_y_valid", y_valid, 8'h00);
    check("mr_sent", sent_count, 16'd0);
    check("mr_dropcnt", drop_count, 8'd0);
    check("mr_in_ready", in_ready, 1'b1);
    check("mr_drop", drop, 1'b0);
    step();
    check("mr_drop_after", drop, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks_r, errors_r);
    $finish;
  end

endmodule
